// File: rtl/gearbox_pkg.sv
`default_nettype none
// =============================================================================
// Module      : gearbox_pkg
// Description : Shared state encodings and width helper for the N:M gearbox.
// Revision    : 1.0 - initial release
// =============================================================================
package gearbox_pkg;

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gearbox_nm.sv
`default_nettype none
// =============================================================================
// Module      : gearbox_nm
// Description : Packet-aware IN_W -> OUT_W bit gearbox with zero-padded tail.
// Revision    : 1.0 - initial release
// =============================================================================
module gearbox_nm
    import gearbox_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 24
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [IN_W-1:0]            in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_valid,
    output logic                       out_last,
    output logic [clog2(OUT_W+1)-1:0]  out_vbits,
    input  logic                       out_ready
);

    localparam int BUF_W = IN_W + OUT_W;
    localparam int CNT_W = clog2(BUF_W + 1);
    localparam int VB_W  = clog2(OUT_W + 1);

    localparam logic [CNT_W-1:0] IN_CNT  = CNT_W'(IN_W);
    localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] ROOM    = CNT_W'(BUF_W - IN_W);

    logic [BUF_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;

    logic             w_push;
    logic             w_pop;
    logic [OUT_W-1:0] w_mask;
    logic [BUF_W-1:0] w_base;
    logic [BUF_W-1:0] w_ins;
    logic [CNT_W-1:0] w_pos;

    // Handshake-facing outputs depend on registers only, never on out_ready.
    always_comb begin
        in_ready  = (r_state == ST_FILL) && (r_cnt <= ROOM);
        out_valid = (r_cnt >= OUT_CNT) || ((r_state == ST_FLUSH) && (r_cnt != '0));
        out_last  = (r_state == ST_FLUSH) && (r_cnt != '0) && (r_cnt <= OUT_CNT);
        out_vbits = out_last ? r_cnt[VB_W-1:0] : VB_W'(OUT_W);

        w_mask = '0;
        for (int i = 0; i < OUT_W; i++) begin
            w_mask[i] = (i < int'(r_cnt));
        end
        out_data = r_acc[OUT_W-1:0] & w_mask;
    end

    // A simultaneous pop shifts the buffer first, so the append lands at cnt-OUT_W.
    always_comb begin
        w_push = in_valid && in_ready;
        w_pop  = out_valid && out_ready;
        w_base = w_pop ? (r_acc >> OUT_W) : r_acc;
        w_pos  = w_pop ? (r_cnt - OUT_CNT) : r_cnt;
        w_ins  = BUF_W'(in_data) << w_pos;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= ST_FILL;
        end else if (w_pop && out_last) begin
            // Tail word leaves: buffer is empty and FLUSH blocks any push.
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= ST_FILL;
        end else begin
            r_acc <= w_base | (w_push ? w_ins : '0);
            r_cnt <= r_cnt + (w_push ? IN_CNT : '0) - (w_pop ? OUT_CNT : '0);
            if (w_push && in_last) begin
                r_state <= ST_FLUSH;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gearbox_nm.sv
`default_nettype none
// =============================================================================
// Module      : tb_gearbox_nm
// Description : Scoreboard bench for gearbox_nm in 32->24 and 24->32 builds.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_gearbox_nm;

    localparam int IA = 32;
    localparam int OA = 24;
    localparam int IB = 24;
    localparam int OB = 32;
    localparam int VA = gearbox_pkg::clog2(OA + 1);
    localparam int VB = gearbox_pkg::clog2(OB + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a, a_in_valid, a_in_last, a_in_ready, a_out_valid, a_out_last, a_out_ready;
    logic [IA-1:0] a_in_data;
    logic [OA-1:0] a_out_data;
    logic [VA-1:0] a_out_vbits;

    logic          rst_b, b_in_valid, b_in_last, b_in_ready, b_out_valid, b_out_last, b_out_ready;
    logic [IB-1:0] b_in_data;
    logic [OB-1:0] b_out_data;
    logic [VB-1:0] b_out_vbits;

    gearbox_nm #(.IN_W(IA), .OUT_W(OA)) dut_a (
        .clk(clk), .reset(rst_a),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_last(a_in_last), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_last(a_out_last),
        .out_vbits(a_out_vbits), .out_ready(a_out_ready)
    );

    gearbox_nm #(.IN_W(IB), .OUT_W(OB)) dut_b (
        .clk(clk), .reset(rst_b),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_last(b_in_last), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_last(b_out_last),
        .out_vbits(b_out_vbits), .out_ready(b_out_ready)
    );

    // Reference model: a plain bit queue per instance, chopped into output words.
    typedef struct {
        logic [255:0] data;
        int           vb;
        bit           last;
    } exp_t;

    exp_t expq[2][$];
    bit   bitq[2][$];
    int   in_lasts[2];
    int   out_lasts[2];
    int   tests = 0;
    int   fails = 0;
    bit   rand_rdy_a = 0;
    bit   rand_rdy_b = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic emit(input int k, input int n, input bit last);
        exp_t e;
        e.data = '0;
        for (int i = 0; i < n; i++) e.data[i] = bitq[k].pop_front();
        e.vb   = n;
        e.last = last;
        expq[k].push_back(e);
    endtask

    task automatic model_accept(input int k, input logic [255:0] d, input int iw, input bit last, input int ow);
        for (int i = 0; i < iw; i++) bitq[k].push_back(d[i]);
        if (last) begin
            while (bitq[k].size() > ow) emit(k, ow, 1'b0);
            emit(k, bitq[k].size(), 1'b1);
            in_lasts[k]++;
        end else begin
            while (bitq[k].size() >= ow) emit(k, ow, 1'b0);
        end
    endtask

    task automatic check_out(input int k, input logic [255:0] d, input bit l, input int vb);
        exp_t e;
        tests++;
        if (expq[k].size() == 0) begin
            fails++;
            $display("FAIL out%0d: unexpected word %0h last=%0b vbits=%0d, none expected", k, d, l, vb);
        end else begin
            e = expq[k].pop_front();
            if (d !== e.data || l !== e.last || vb != e.vb) begin
                fails++;
                $display("FAIL out%0d: got %0h last=%0b vbits=%0d expected %0h last=%0b vbits=%0d",
                         k, d, l, vb, e.data, e.last, e.vb);
            end
        end
        if (l) out_lasts[k]++;
    endtask

    task automatic discard(input int k);
        foreach (expq[k][i]) if (expq[k][i].last) in_lasts[k]--;
        expq[k].delete();
        bitq[k].delete();
    endtask

    // Monitors sample on the falling edge, where everything the next rising edge sees is settled.
    initial begin : mon_a
        logic [255:0] held;
        bit stall;
        stall = 0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (rst_a) begin
                discard(0);
                stall = 0;
            end else begin
                if (a_in_valid && a_in_ready) model_accept(0, 256'(a_in_data), IA, a_in_last, OA);
                if (stall) check("hold_a", 256'({a_out_data, a_out_last, a_out_vbits}), held);
                if (a_out_valid && a_out_ready)
                    check_out(0, 256'(a_out_data), a_out_last, int'(a_out_vbits));
                stall = a_out_valid && !a_out_ready;
                held  = 256'({a_out_data, a_out_last, a_out_vbits});
            end
        end
    end

    initial begin : mon_b
        logic [255:0] held;
        bit stall;
        stall = 0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (rst_b) begin
                discard(1);
                stall = 0;
            end else begin
                if (b_in_valid && b_in_ready) model_accept(1, 256'(b_in_data), IB, b_in_last, OB);
                if (stall) check("hold_b", 256'({b_out_data, b_out_last, b_out_vbits}), held);
                if (b_out_valid && b_out_ready)
                    check_out(1, 256'(b_out_data), b_out_last, int'(b_out_vbits));
                stall = b_out_valid && !b_out_ready;
                held  = 256'({b_out_data, b_out_last, b_out_vbits});
            end
        end
    end

    initial begin : rdy_gen
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy_a) a_out_ready = ($urandom_range(0, 3) != 0);
            if (rand_rdy_b) b_out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : watchdog
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [IA-1:0] d, input bit l);
        a_in_data  = d;
        a_in_last  = l;
        a_in_valid = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (a_in_ready) break;
            if (t > 200) begin
                tests++;
                fails++;
                $display("FAIL send_a: in_ready 0 after %0d cycles, required 1", t);
                break;
            end
        end
        step();
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
    endtask

    task automatic send_b(input logic [IB-1:0] d, input bit l);
        b_in_data  = d;
        b_in_last  = l;
        b_in_valid = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (b_in_ready) break;
            if (t > 200) begin
                tests++;
                fails++;
                $display("FAIL send_b: in_ready 0 after %0d cycles, required 1", t);
                break;
            end
        end
        step();
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
    endtask

    task automatic drain(input int k);
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (expq[k].size() == 0 && !(k == 0 ? a_out_valid : b_out_valid)) break;
            if (t > 2000) begin
                tests++;
                fails++;
                $display("FAIL drain%0d: %0d words pending, required 0", k, expq[k].size());
                break;
            end
        end
        step();
    endtask

    initial begin : main
        rst_a = 1; rst_b = 1;
        a_in_data = '0; a_in_valid = 0; a_in_last = 0; a_out_ready = 0;
        b_in_data = '0; b_in_valid = 0; b_in_last = 0; b_out_ready = 0;
        in_lasts  = '{0, 0};
        out_lasts = '{0, 0};
        step();
        step();
        @(negedge clk);
        check("rst_in_ready_a", 256'(a_in_ready), 256'(1));
        check("rst_out_valid_a", 256'(a_out_valid), 256'(0));
        check("rst_out_last_a", 256'(a_out_last), 256'(0));
        check("rst_out_data_a", 256'(a_out_data), 256'(0));
        check("rst_out_vbits_a", 256'(a_out_vbits), 256'(OA));
        check("rst_in_ready_b", 256'(b_in_ready), 256'(1));
        check("rst_out_valid_b", 256'(b_out_valid), 256'(0));
        check("rst_out_vbits_b", 256'(b_out_vbits), 256'(OB));
        step();
        rst_a = 0; rst_b = 0;
        @(negedge clk);
        check("post_rst_in_ready_a", 256'(a_in_ready), 256'(1));
        step();

        // Three words, last on the third, into four 24-bit outputs.
        a_out_ready = 1;
        send_a(32'h33221100, 0);
        send_a(32'h77665544, 0);
        send_a(32'hBBAA9988, 1);
        drain(0);

        // Single word packet: input stays blocked until the tail word leaves.
        send_a(32'hDEADBEEF, 1);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (!a_out_valid) break;
            check("flush_in_ready_a", 256'(a_in_ready), 256'(0));
        end
        check("ready_after_flush_a", 256'(a_in_ready), 256'(1));
        drain(0);

        // Backpressure: one stored word fills past the room threshold.
        a_out_ready = 0;
        send_a(32'h76543210, 0);
        @(negedge clk);
        check("bp_in_ready_a", 256'(a_in_ready), 256'(0));
        check("bp_out_valid_a", 256'(a_out_valid), 256'(1));
        repeat (5) step();
        a_out_ready = 1;
        send_a(32'hFEDCBA98, 1);
        drain(0);

        // Reset pulse during FLUSH with 8 bits pending.
        a_out_ready = 0;
        send_a(32'hDEADBEEF, 1);
        a_out_ready = 1;
        step();
        a_out_ready = 0;
        @(negedge clk);
        check("tail_vbits_a", 256'(a_out_vbits), 256'(8));
        check("tail_last_a", 256'(a_out_last), 256'(1));
        check("tail_data_a", 256'(a_out_data), 256'(24'h0000DE));
        step();
        rst_a = 1;
        step();
        rst_a = 0;
        @(negedge clk);
        check("mid_rst_out_valid_a", 256'(a_out_valid), 256'(0));
        check("mid_rst_in_ready_a", 256'(a_in_ready), 256'(1));
        step();
        a_out_ready = 1;
        send_a(32'h01234567, 1);
        drain(0);

        // 24 -> 32: exact multiple, no pad word.
        b_out_ready = 1;
        send_b(24'h020100, 0);
        send_b(24'h050403, 0);
        send_b(24'h080706, 0);
        send_b(24'h0B0A09, 1);
        drain(1);

        // Random traffic with idle gaps and stray in_last on idle cycles.
        rand_rdy_a = 1;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                a_in_last = 1'($urandom_range(0, 1));
                a_in_data = $urandom;
                step();
                a_in_last = 0;
            end
            send_a($urandom, (n == 9999) || ($urandom_range(0, 7) == 0));
        end
        rand_rdy_a = 0;
        a_out_ready = 1;
        drain(0);

        rand_rdy_b = 1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                b_in_last = 1'($urandom_range(0, 1));
                step();
                b_in_last = 0;
            end
            send_b(24'($urandom), (n == 1499) || ($urandom_range(0, 5) == 0));
        end
        rand_rdy_b = 0;
        b_out_ready = 1;
        drain(1);

        check("pending_a", 256'(expq[0].size()), 256'(0));
        check("pending_b", 256'(expq[1].size()), 256'(0));
        check("last_count_a", 256'(out_lasts[0]), 256'(in_lasts[0]));
        check("last_count_b", 256'(out_lasts[1]), 256'(in_lasts[1]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
